// File: rtl/enc_pkg.sv
// Shared definitions for the RS encoder datapath: phase encoding and default code geometry.
package enc_pkg;

  // Default code geometry: RS(255,223) with four symbols per beat.
  localparam int ENC_SYM_NUM = 4;
  localparam int RS_COD_LEN  = 255;
  localparam int RS_MSG_LEN  = 223;

  // Sequencer phase. Values are fixed so downstream logic can decode them directly.
  typedef enum logic [1:0] {
    CON_IDL = 2'd0,
    CON_STA = 2'd1,
    CON_WOR = 2'd2,
    CON_DRN = 2'd3
  } CON_PHASE;

endpackage

// File: rtl/enc_lane_pos.sv
// Per-lane codeword position decode: given lane-0 position and the latched n/k,
// produces SOP/EOP/parity masks and the position of lane 0 for the following beat.
module enc_lane_pos
  import enc_pkg::*;
#(
  parameter int SYM_NUM = ENC_SYM_NUM,
  parameter int POS_W   = 8
) (
  input  logic [POS_W-1:0]   pos,
  input  logic [POS_W-1:0]   cod_len,
  input  logic [POS_W-1:0]   msg_len,
  output logic [SYM_NUM-1:0] sop,
  output logic [SYM_NUM-1:0] eop,
  output logic [SYM_NUM-1:0] par,
  output logic [POS_W-1:0]   pos_nxt
);

  // One extra bit so pos + lane offset never truncates before the wrap compare.
  logic [POS_W:0] n_ext;
  logic [POS_W:0] k_ext;
  logic [POS_W:0] last_pos;
  logic [POS_W:0] nxt_sum;

  assign n_ext    = {1'b0, cod_len};
  assign k_ext    = {1'b0, msg_len};
  assign last_pos = n_ext - (POS_W+1)'(1);
  assign nxt_sum  = {1'b0, pos} + (POS_W+1)'(SYM_NUM);

  // SYM_NUM <= n guarantees at most one wrap per beat, so a single subtract suffices.
  assign pos_nxt = POS_W'((nxt_sum >= n_ext) ? nxt_sum - n_ext : nxt_sum);

  for (genvar j = 0; j < SYM_NUM; j++) begin : g_lane
    logic [POS_W:0] lane_sum;
    logic [POS_W:0] lane_p;

    assign lane_sum = {1'b0, pos} + (POS_W+1)'(j);
    assign lane_p   = (lane_sum >= n_ext) ? lane_sum - n_ext : lane_sum;
    assign sop[j]   = (lane_p == '0);
    assign eop[j]   = (lane_p == last_pos);
    assign par[j]   = (lane_p >= k_ext);
  end

endmodule

// File: rtl/enc_sequencer.sv
// Codeword sequencer for the RS encoder: tracks symbol position across multi-lane beats,
// runs a start/work/drain phase FSM and emits per-lane steering masks.
module enc_sequencer
  import enc_pkg::*;
#(
  parameter int SYM_NUM     = ENC_SYM_NUM,
  parameter int COD_LEN_MAX = RS_COD_LEN,
  parameter int POS_W       = $clog2(COD_LEN_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [POS_W-1:0]   cfg_cod_len,
  input  logic [POS_W-1:0]   cfg_msg_len,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  output CON_PHASE           phase,
  output logic [POS_W-1:0]   pos,
  output logic [SYM_NUM-1:0] lane_vld,
  output logic [SYM_NUM-1:0] lane_sop,
  output logic [SYM_NUM-1:0] lane_eop,
  output logic [SYM_NUM-1:0] lane_par,
  output logic               cw_done
);

  CON_PHASE         phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] n_q, n_d;
  logic [POS_W-1:0] k_q, k_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cw_done_q, cw_done_d;

  logic [SYM_NUM-1:0] raw_sop;
  logic [SYM_NUM-1:0] raw_eop;
  logic [SYM_NUM-1:0] raw_par;
  logic [POS_W-1:0]   pos_nxt;
  logic               fire;
  logic               eop_any;
  logic               eop_seen;
  logic               cfg_ok;
  logic [POS_W:0]     n_in;
  logic [POS_W:0]     k_in;

  enc_lane_pos #(
    .SYM_NUM (SYM_NUM),
    .POS_W   (POS_W)
  ) u_lane_pos (
    .pos     (pos_q),
    .cod_len (n_q),
    .msg_len (k_q),
    .sop     (raw_sop),
    .eop     (raw_eop),
    .par     (raw_par),
    .pos_nxt (pos_nxt)
  );

  assign in_ready = (phase_q == CON_WOR) || (phase_q == CON_DRN);
  assign fire     = in_valid & in_ready;
  assign eop_any  = |raw_eop;

  assign phase   = phase_q;
  assign pos     = pos_q;
  assign cfg_err = cfg_err_q;
  assign cw_done = cw_done_q;

  // Widened so an out-of-range length cannot alias into a legal one.
  assign n_in = {1'b0, cfg_cod_len};
  assign k_in = {1'b0, cfg_msg_len};

  // Accept a configuration only if at least one full beat fits and k leaves room for parity.
  always_comb begin
    cfg_ok = (n_in >= (POS_W+1)'(SYM_NUM)) &&
             (n_in <= (POS_W+1)'(COD_LEN_MAX)) &&
             (k_in != '0) &&
             (k_in < n_in);
  end

  // Lane masks; while draining, lanes beyond the first EOP belong to no codeword.
  always_comb begin
    lane_sop = '0;
    lane_eop = '0;
    lane_par = '0;
    lane_vld = '0;
    eop_seen = 1'b0;
    if (in_ready) begin
      lane_sop = raw_sop;
      lane_eop = raw_eop;
      lane_par = raw_par;
      for (int j = 0; j < SYM_NUM; j++) begin
        lane_vld[j] = !((phase_q == CON_DRN) && eop_seen);
        eop_seen    = eop_seen | raw_eop[j];
      end
    end
  end

  // Phase FSM and position advance; nothing moves on a stalled beat.
  always_comb begin
    phase_d   = phase_q;
    pos_d     = pos_q;
    n_d       = n_q;
    k_d       = k_q;
    cfg_err_d = 1'b0;
    cw_done_d = fire & eop_any;
    case (phase_q)
      CON_IDL: begin
        if (start) begin
          if (cfg_ok) begin
            phase_d = CON_STA;
            n_d     = cfg_cod_len;
            k_d     = cfg_msg_len;
            pos_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CON_STA: begin
        phase_d = CON_WOR;
      end
      CON_WOR: begin
        if (fire) begin
          pos_d = pos_nxt;
        end
        if (stop) begin
          if (fire && eop_any) begin
            phase_d = CON_IDL;
            pos_d   = '0;
          end else begin
            phase_d = CON_DRN;
          end
        end
      end
      CON_DRN: begin
        if (fire) begin
          if (eop_any) begin
            phase_d = CON_IDL;
            pos_d   = '0;
          end else begin
            pos_d = pos_nxt;
          end
        end
      end
      default: begin
        phase_d = CON_IDL;
        pos_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any partial codeword immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= CON_IDL;
      pos_q     <= '0;
      n_q       <= '0;
      k_q       <= '0;
      cfg_err_q <= 1'b0;
      cw_done_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      n_q       <= n_d;
      k_q       <= k_d;
      cfg_err_q <= cfg_err_d;
      cw_done_q <= cw_done_d;
    end
  end

endmodule

// File: tb/tb_enc_sequencer.sv
// Self-checking bench for enc_sequencer (SYM_NUM=4, COD_LEN_MAX=255) using a reference
// model whose per-cycle expectations go through a scoreboard queue.
module tb_enc_sequencer;
  import enc_pkg::*;

  localparam int SYM   = 4;
  localparam int POS_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [POS_W-1:0] cfg_cod_len;
  logic [POS_W-1:0] cfg_msg_len;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  CON_PHASE         phase;
  logic [POS_W-1:0] pos;
  logic [SYM-1:0]   lane_vld;
  logic [SYM-1:0]   lane_sop;
  logic [SYM-1:0]   lane_eop;
  logic [SYM-1:0]   lane_par;
  logic             cw_done;

  enc_sequencer #(
    .SYM_NUM     (SYM),
    .COD_LEN_MAX (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_cod_len (cfg_cod_len),
    .cfg_msg_len (cfg_msg_len),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .phase       (phase),
    .pos         (pos),
    .lane_vld    (lane_vld),
    .lane_sop    (lane_sop),
    .lane_eop    (lane_eop),
    .lane_par    (lane_par),
    .cw_done     (cw_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     phase;
    logic           rdy;
    logic [7:0]     pos;
    logic [SYM-1:0] vld;
    logic [SYM-1:0] sop;
    logic [SYM-1:0] eop;
    logic [SYM-1:0] par;
    logic           cw;
    logic           cerr;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cw_seen  = 0;
  int fires    = 0;

  // Reference model state
  CON_PHASE m_phase;
  int       m_pos;
  int       m_n;
  int       m_k;
  logic     m_cw;
  logic     m_cerr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   p;
    bit   seen;
    e.phase = m_phase;
    e.rdy   = (m_phase == CON_WOR) || (m_phase == CON_DRN);
    e.pos   = 8'(m_pos);
    e.cw    = m_cw;
    e.cerr  = m_cerr;
    e.vld   = '0;
    e.sop   = '0;
    e.eop   = '0;
    e.par   = '0;
    seen    = 1'b0;
    if (e.rdy) begin
      for (int j = 0; j < SYM; j++) begin
        p        = (m_pos + j) % m_n;
        e.sop[j] = (p == 0);
        e.eop[j] = (p == m_n - 1);
        e.par[j] = (p >= m_k);
        e.vld[j] = !((m_phase == CON_DRN) && seen);
        if (p == m_n - 1) seen = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_phase = CON_IDL;
    m_pos   = 0;
    m_n     = 0;
    m_k     = 0;
    m_cw    = 1'b0;
    m_cerr  = 1'b0;
  endtask

  task automatic model_update(input logic s_start, input logic s_stop, input logic s_valid);
    exp_t e;
    bit   f;
    bit   ea;
    bit   ok;
    e  = model_out();
    f  = s_valid && e.rdy;
    ea = |e.eop;
    m_cw   = f && ea;
    m_cerr = 1'b0;
    if (f) fires++;
    case (m_phase)
      CON_IDL: begin
        if (s_start) begin
          ok = (int'(cfg_cod_len) >= SYM) && (int'(cfg_cod_len) <= 255) &&
               (cfg_msg_len != 0) && (cfg_msg_len < cfg_cod_len);
          if (ok) begin
            m_phase = CON_STA;
            m_n     = int'(cfg_cod_len);
            m_k     = int'(cfg_msg_len);
            m_pos   = 0;
          end else begin
            m_cerr = 1'b1;
          end
        end
      end
      CON_STA: m_phase = CON_WOR;
      CON_WOR: begin
        if (f) m_pos = (m_pos + SYM) % m_n;
        if (s_stop) begin
          if (f && ea) begin
            m_phase = CON_IDL;
            m_pos   = 0;
          end else begin
            m_phase = CON_DRN;
          end
        end
      end
      default: begin
        if (f) begin
          if (ea) begin
            m_phase = CON_IDL;
            m_pos   = 0;
          end else begin
            m_pos = (m_pos + SYM) % m_n;
          end
        end
      end
    endcase
  endtask

  // One cycle: called just after a rising edge; drives, checks at negedge, advances model.
  task automatic step(input logic s_start, input logic s_stop, input logic s_valid);
    exp_t e;
    start    = s_start;
    stop     = s_stop;
    in_valid = s_valid;
    exp_q.push_back(model_out());
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("phase", phase, e.phase);
      check_eq("in_ready", in_ready, e.rdy);
      check_eq("pos", pos, e.pos);
      check_eq("lane_vld", lane_vld, e.vld);
      check_eq("lane_sop", lane_sop, e.sop);
      check_eq("lane_eop", lane_eop, e.eop);
      check_eq("lane_par", lane_par, e.par);
      check_eq("cw_done", cw_done, e.cw);
      check_eq("cfg_err", cfg_err, e.cerr);
      if (m_n == 255 && m_k == 223 && e.rdy) begin
        if (m_pos == 252) begin
          check_eq("eop252", lane_eop, 4'b0100);
          check_eq("sop252", lane_sop, 4'b1000);
          if (m_phase == CON_DRN) check_eq("vld252_drn", lane_vld, 4'b0111);
        end
        if (m_pos == 220) check_eq("par220", lane_par, 4'b1000);
        if (m_pos == 224) check_eq("par224", lane_par, 4'b1111);
      end
      if (m_n == 10 && e.rdy && m_pos == 8) begin
        check_eq("sop_n10_pos8", lane_sop, 4'b0100);
        check_eq("eop_n10_pos8", lane_eop, 4'b0010);
      end
    end
    if (cw_done) cw_seen++;
    @(posedge clk);
    model_update(s_start, s_stop, s_valid);
    #1;
  endtask

  task automatic drain_to_idle();
    for (int i = 0; i < 200 && m_phase != CON_IDL; i++) step(1'b0, 1'b0, 1'b1);
    check_eq("drain_idle", phase, CON_IDL);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_phase"}, phase, CON_IDL);
    check_eq({tag, "_pos"}, pos, 0);
    check_eq({tag, "_ready"}, in_ready, 0);
    check_eq({tag, "_vld"}, lane_vld, 0);
    check_eq({tag, "_sop"}, lane_sop, 0);
    check_eq({tag, "_eop"}, lane_eop, 0);
    check_eq({tag, "_par"}, lane_par, 0);
    check_eq({tag, "_cw"}, cw_done, 0);
    check_eq({tag, "_cerr"}, cfg_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cw0;
    int f0;
    int exp_pos[5];
    exp_pos = '{0, 4, 8, 2, 6};

    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    in_valid    = 1'b0;
    cfg_cod_len = 8'd0;
    cfg_msg_len = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-length codeword across a wrap beat
    cfg_cod_len = 8'd255;
    cfg_msg_len = 8'd223;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cw0 = cw_seen;
    repeat (64) step(1'b0, 1'b0, 1'b1);
    check_eq("t1_pos_wrap", pos, 1);
    check_eq("t1_cw_pulse", cw_done, 1);
    step(1'b0, 1'b0, 1'b1);
    check_eq("t1_cw_once", cw_seen - cw0, 1);
    step(1'b0, 1'b1, 1'b1);
    drain_to_idle();

    // Random backpressure
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cw0 = cw_seen;
    f0  = fires;
    repeat (1000) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b0);
    check_eq("t3_cw_cnt", cw_seen - cw0, ((fires - f0) * SYM) / 255);
    step(1'b0, 1'b1, 1'b0);
    drain_to_idle();

    // Stop mid-codeword, drain to EOP
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    check_eq("t4_pos100", pos, 100);
    step(1'b0, 1'b1, 1'b1);
    check_eq("t4_drn", phase, CON_DRN);
    check_eq("t4_drn_ready", in_ready, 1);
    drain_to_idle();
    check_eq("t4_idle_pos", pos, 0);
    check_eq("t4_idle_ready", in_ready, 0);

    // Rejected configurations
    cfg_cod_len = 8'd3;
    cfg_msg_len = 8'd2;
    step(1'b1, 1'b0, 1'b0);
    check_eq("t5_err_short", cfg_err, 1);
    check_eq("t5_idle_short", phase, CON_IDL);
    step(1'b0, 1'b0, 1'b0);
    check_eq("t5_err_pulse", cfg_err, 0);
    cfg_cod_len = 8'd10;
    cfg_msg_len = 8'd10;
    step(1'b1, 1'b0, 1'b0);
    check_eq("t5_err_keqn", cfg_err, 1);
    check_eq("t5_idle_keqn", phase, CON_IDL);
    cfg_msg_len = 8'd0;
    step(1'b1, 1'b0, 1'b0);
    check_eq("t5_err_k0", cfg_err, 1);
    step(1'b0, 1'b0, 1'b0);

    // Short code n=10, k=6, then asynchronous reset mid-beat
    cfg_msg_len = 8'd6;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("t6_pos", pos, exp_pos[i]);
      step(1'b0, 1'b0, 1'b1);
    end
    check_eq("t6_pos_wrap0", pos, 0);
    check_eq("t6_cw", cw_done, 1);
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
